// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter that lets two requesters (A, B) share
// one register bus. A grant is taken in IDLE. The latched transaction is then
// driven on the bus for one cycle (BUS). Reads wait one more cycle (RWAIT) for
// the slave's registered data. The granted requester gets a one-cycle ack (ACK).
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_{a,b}_req/we/addr/wdata    requester transaction inputs (req is level, held until ack)
//   o_{a,b}_ack                  one-cycle completion pulse to the granted requester
//   o_rdata, o_err               read data / error flag, valid in the ack cycle
//   o_busy                       high whenever the FSM is not in IDLE
//   o_addr, o_wdata, o_wen       register-bus address, write data, write strobe
//   i_q                          register-bus read data (valid one cycle after o_addr)
//
// Configuration
//   REG_BUS_ARB_ADDR_CHK_EN      when defined, only addresses 0x0000/2/4/6 reach the
//                                bus. Any other address is acked at once with o_err=1.
module reg_bus_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_a_req,
   input  logic              i_a_we,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic              o_a_ack,
   input  logic              i_b_req,
   input  logic              i_b_we,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic              o_b_ack,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_err,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_wen,
   input  logic [DATA_W-1:0] i_q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      RWAIT = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t state;
   logic   ptr;      // 0 = A preferred, 1 = B preferred
   logic   gnt_b;    // granted requester of the transaction in flight
   logic   lat_we;   // latched direction of the transaction in flight

   logic              any_req_c;
   logic              grant_b_c;
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              addr_ok_c;

   // Arbitration: a sole requester wins; on a tie the pointer decides.
   always_comb begin
      any_req_c   = i_a_req | i_b_req;
      grant_b_c   = i_b_req & (~i_a_req | ptr);
      sel_we_c    = grant_b_c ? i_b_we    : i_a_we;
      sel_addr_c  = grant_b_c ? i_b_addr  : i_a_addr;
      sel_wdata_c = grant_b_c ? i_b_wdata : i_a_wdata;
   end

   // Address window: only the four even word addresses 0..6 are decoded.
`ifdef REG_BUS_ARB_ADDR_CHK_EN
   always_comb begin
      addr_ok_c = (sel_addr_c[ADDR_W-1:3] == '0) && (sel_addr_c[0] == 1'b0);
   end
`else
   always_comb begin
      addr_ok_c = 1'b1;
   end
`endif

   // FSM with all outputs registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         gnt_b   <= 1'b0;
         lat_we  <= 1'b0;
         o_a_ack <= 1'b0;
         o_b_ack <= 1'b0;
         o_rdata <= '0;
         o_err   <= 1'b0;
         o_busy  <= 1'b0;
         o_addr  <= '0;
         o_wdata <= '0;
         o_wen   <= 1'b0;
      end else begin
         // Pulse outputs default low; only the cycle entering their state raises them.
         o_a_ack <= 1'b0;
         o_b_ack <= 1'b0;
         o_wen   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req_c) begin
                  gnt_b   <= grant_b_c;
                  lat_we  <= sel_we_c;
                  ptr     <= ~grant_b_c;
                  o_rdata <= '0;
                  o_busy  <= 1'b1;
                  if (addr_ok_c) begin
                     state   <= BUS;
                     o_addr  <= sel_addr_c;
                     o_wdata <= sel_wdata_c;
                     o_wen   <= sel_we_c;
                     o_err   <= 1'b0;
                  end else begin
                     // Rejected address: skip the bus and ack with error next cycle.
                     state   <= ACK;
                     o_err   <= 1'b1;
                     o_a_ack <= ~grant_b_c;
                     o_b_ack <= grant_b_c;
                  end
               end
            end
            BUS: begin
               if (lat_we) begin
                  state   <= ACK;
                  o_a_ack <= ~gnt_b;
                  o_b_ack <= gnt_b;
               end else begin
                  state <= RWAIT;
               end
            end
            RWAIT: begin
               // Slave data is valid now, one cycle after the address was presented.
               state   <= ACK;
               o_rdata <= i_q;
               o_a_ack <= ~gnt_b;
               o_b_ack <= gnt_b;
            end
            ACK: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_err  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed self-checking bench for reg_bus_arbiter.
// Inputs change and outputs are sampled on the falling edge. The DUT acts on the rising edge.
// Cycle c of a scenario is the c-th falling edge after the request is raised.
// Cycle 0 is the IDLE cycle in which the request is sampled.
module tb_reg_bus_arbiter;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_a_req, i_a_we, i_b_req, i_b_we;
   logic [ADDR_W-1:0] i_a_addr, i_b_addr;
   logic [DATA_W-1:0] i_a_wdata, i_b_wdata;
   logic              o_a_ack, o_b_ack, o_err, o_busy, o_wen;
   logic [DATA_W-1:0] o_rdata, o_wdata;
   logic [ADDR_W-1:0] o_addr;
   logic [DATA_W-1:0] i_q = '0;

   int checks   = 0;
   int failures = 0;

   reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
      .o_a_ack(o_a_ack),
      .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
      .o_b_ack(o_b_ack),
      .o_rdata(o_rdata), .o_err(o_err), .o_busy(o_busy),
      .o_addr(o_addr), .o_wdata(o_wdata), .o_wen(o_wen), .i_q(i_q)
   );

   always #5 i_clk = ~i_clk;

   // Slave: registered read data. Address 0x0004 reads as 0xBEEF, everything else as 0x0BAD.
   always @(posedge i_clk) begin
      i_q <= (o_addr == 16'h0004) ? 16'hBEEF : 16'h0BAD;
   end

   task automatic test_reset();
      i_rst = 1'b1;
      i_a_req = 1'b0; i_a_we = 1'b0; i_a_addr = '0; i_a_wdata = '0;
      i_b_req = 1'b0; i_b_we = 1'b0; i_b_addr = '0; i_b_wdata = '0;
      repeat (3) @(negedge i_clk);
      checks++;
      if ({o_a_ack, o_b_ack, o_err, o_busy, o_wen} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000", {o_a_ack, o_b_ack, o_err, o_busy, o_wen});
      end
      checks++;
      if (o_rdata !== 16'h0 || o_addr !== 16'h0 || o_wdata !== 16'h0) begin
         failures++;
         $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp 0", o_rdata, o_addr, o_wdata);
      end
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_write_a();
      int wen_cnt = 0;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 16'h0002; i_a_wdata = 16'h1234;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         if (o_wen) wen_cnt++;
         if (c == 1) begin
            checks++;
            if (o_wen !== 1'b1 || o_addr !== 16'h0002 || o_wdata !== 16'h1234 || o_busy !== 1'b1) begin
               failures++;
               $display("FAIL wr_bus got wen=%b addr=%h wdata=%h busy=%b exp 1/0002/1234/1",
                        o_wen, o_addr, o_wdata, o_busy);
            end
         end
         checks++;
         if (o_a_ack !== (c == 2) || o_b_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack cyc=%0d got a=%b b=%b exp a=%b b=0", c, o_a_ack, o_b_ack, c == 2);
         end
         if (c == 2) begin
            checks++;
            if (o_err !== 1'b0 || o_rdata !== 16'h0 || o_busy !== 1'b1) begin
               failures++;
               $display("FAIL wr_ack_data got err=%b rdata=%h busy=%b exp 0/0000/1", o_err, o_rdata, o_busy);
            end
            i_a_req = 1'b0;
         end
      end
      checks++;
      if (wen_cnt != 1 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL wr_wen_count got wen=%0d busy=%b exp 1 0", wen_cnt, o_busy);
      end
   endtask

   task automatic test_read_b();
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 16'h0004; i_b_wdata = 16'h7777;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         checks++;
         if (o_wen !== 1'b0) begin
            failures++;
            $display("FAIL rd_wen cyc=%0d got=%b exp=0", c, o_wen);
         end
         if (c == 1) begin
            checks++;
            if (o_addr !== 16'h0004) begin
               failures++;
               $display("FAIL rd_addr got=%h exp=0004", o_addr);
            end
         end
         checks++;
         if (o_b_ack !== (c == 3) || o_a_ack !== 1'b0) begin
            failures++;
            $display("FAIL rd_ack cyc=%0d got a=%b b=%b exp a=0 b=%b", c, o_a_ack, o_b_ack, c == 3);
         end
         if (c == 3) begin
            checks++;
            if (o_rdata !== 16'hBEEF || o_err !== 1'b0) begin
               failures++;
               $display("FAIL rd_data got rdata=%h err=%b exp BEEF 0", o_rdata, o_err);
            end
            i_b_req = 1'b0;
         end
      end
   endtask

   task automatic test_round_robin();
      logic exp_a, exp_b;
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 16'h0000; i_a_wdata = 16'h1111;
      i_b_req = 1'b1; i_b_we = 1'b1; i_b_addr = 16'h0006; i_b_wdata = 16'h2222;
      for (int c = 1; c <= 12; c++) begin
         @(negedge i_clk);
         exp_a = ((c % 6) == 2);
         exp_b = ((c % 6) == 5);
         checks++;
         if (o_a_ack !== exp_a || o_b_ack !== exp_b) begin
            failures++;
            $display("FAIL rr_ack cyc=%0d got a=%b b=%b exp a=%b b=%b", c, o_a_ack, o_b_ack, exp_a, exp_b);
         end
         if ((c % 3) == 1) begin
            checks++;
            if (o_wen !== 1'b1 || o_addr !== (((c % 6) == 1) ? 16'h0000 : 16'h0006)) begin
               failures++;
               $display("FAIL rr_bus cyc=%0d got wen=%b addr=%h", c, o_wen, o_addr);
            end
         end
      end
      i_a_req = 1'b0; i_b_req = 1'b0;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic test_reset_mid();
      // The A read flips the pointer toward B. Reset must restore A preference.
      i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 16'h0004;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         if (c == 2) begin
            i_rst = 1'b1;
            i_a_req = 1'b0;
         end
         if (c == 3) begin
            checks++;
            if ({o_a_ack, o_b_ack, o_err, o_busy, o_wen} !== 5'b0 ||
                o_rdata !== 16'h0 || o_addr !== 16'h0 || o_wdata !== 16'h0) begin
               failures++;
               $display("FAIL mid_reset_outs got flags=%b rdata=%h addr=%h wdata=%h exp all 0",
                        {o_a_ack, o_b_ack, o_err, o_busy, o_wen}, o_rdata, o_addr, o_wdata);
            end
            i_rst = 1'b0;
         end
         if (c == 4) begin
            checks++;
            if (o_a_ack !== 1'b0 || o_b_ack !== 1'b0 || o_wen !== 1'b0) begin
               failures++;
               $display("FAIL mid_reset_noack got a=%b b=%b wen=%b exp 0", o_a_ack, o_b_ack, o_wen);
            end
         end
      end
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 16'h0000; i_a_wdata = 16'hAAAA;
      i_b_req = 1'b1; i_b_we = 1'b1; i_b_addr = 16'h0006; i_b_wdata = 16'hBBBB;
      for (int c = 1; c <= 6; c++) begin
         @(negedge i_clk);
         if (c == 1) begin
            checks++;
            if (o_wen !== 1'b1 || o_addr !== 16'h0000 || o_wdata !== 16'hAAAA) begin
               failures++;
               $display("FAIL mid_first_grant got wen=%b addr=%h wdata=%h exp 1/0000/AAAA", o_wen, o_addr, o_wdata);
            end
         end
         if (c == 2) begin
            checks++;
            if (o_a_ack !== 1'b1 || o_b_ack !== 1'b0) begin
               failures++;
               $display("FAIL mid_first_ack got a=%b b=%b exp a=1 b=0", o_a_ack, o_b_ack);
            end
            i_a_req = 1'b0;
         end
         if (c == 5) begin
            checks++;
            if (o_b_ack !== 1'b1 || o_a_ack !== 1'b0) begin
               failures++;
               $display("FAIL mid_second_ack got a=%b b=%b exp a=0 b=1", o_a_ack, o_b_ack);
            end
            i_b_req = 1'b0;
         end
      end
   endtask

   task automatic test_ignore_outside_idle();
      int b_acks = 0;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 16'h0006; i_a_wdata = 16'h3C3C;
      for (int c = 1; c <= 6; c++) begin
         @(negedge i_clk);
         if (o_b_ack) b_acks++;
         if (c == 1) begin
            i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 16'h0004;
         end
         if (c == 2) begin
            checks++;
            if (o_a_ack !== 1'b1) begin
               failures++;
               $display("FAIL ign_a_ack got=%b exp=1", o_a_ack);
            end
            i_a_req = 1'b0;
            i_b_req = 1'b0;
         end
      end
      checks++;
      if (b_acks != 0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL ign_b_dropped got b_acks=%0d busy=%b exp 0 0", b_acks, o_busy);
      end
   endtask

   task automatic test_addr_chk();
      int wen_cnt = 0;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 16'h0008; i_a_wdata = 16'h5555;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         if (o_wen) wen_cnt++;
`ifdef REG_BUS_ARB_ADDR_CHK_EN
         if (c == 1) begin
            checks++;
            if (o_a_ack !== 1'b1 || o_err !== 1'b1 || o_rdata !== 16'h0) begin
               failures++;
               $display("FAIL chk_ack got ack=%b err=%b rdata=%h exp 1/1/0000", o_a_ack, o_err, o_rdata);
            end
            i_a_req = 1'b0;
         end
`else
         if (c == 1) begin
            checks++;
            if (o_wen !== 1'b1 || o_addr !== 16'h0008 || o_wdata !== 16'h5555) begin
               failures++;
               $display("FAIL chk_bus got wen=%b addr=%h wdata=%h exp 1/0008/5555", o_wen, o_addr, o_wdata);
            end
         end
         if (c == 2) begin
            checks++;
            if (o_a_ack !== 1'b1 || o_err !== 1'b0) begin
               failures++;
               $display("FAIL chk_ack got ack=%b err=%b exp 1 0", o_a_ack, o_err);
            end
            i_a_req = 1'b0;
         end
`endif
      end
      checks++;
`ifdef REG_BUS_ARB_ADDR_CHK_EN
      if (wen_cnt != 0) begin
         failures++;
         $display("FAIL chk_wen got=%0d exp=0", wen_cnt);
      end
`else
      if (wen_cnt != 1) begin
         failures++;
         $display("FAIL chk_wen got=%0d exp=1", wen_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write_a();
      test_read_b();
      test_round_robin();
      test_reset_mid();
      test_ignore_outside_idle();
      test_addr_chk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
